// File: rtl/writeback_arbiter_pkg.sv
// Shared types and sizing for the writeback arbiter.
// The packed entry keeps the destination register next to the result data.
package writeback_arbiter_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned N_WB_SRC = 3;
    localparam int unsigned WB_DEPTH = 2;

    typedef struct packed {
        logic [4:0]      adr;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_slot_fifo.sv
// Small per-source result buffer.
// The flush input empties the buffer and discards that cycle's push.
module wb_slot_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output wb_entry_t                head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_q[tail_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PTR_ONE;
            if (pop)  head_q <= head_q + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = mem_q[head_q];

endmodule

// File: rtl/writeback_arbiter.sv
// Serialises buffered results from the calculation units onto the single
// register-file write port using round-robin arbitration.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned N_SRC = N_WB_SRC,
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_SRC-1:0]      src_v,
    input  logic [N_SRC*5-1:0]    src_adr,
    input  logic [N_SRC*XLEN-1:0] src_data,
    output logic [N_SRC-1:0]      src_ok_o,
    input  logic                  flush,
    output logic                  res_v,
    output logic [4:0]            res_adr,
    output logic [XLEN-1:0]       res_data,
    output logic                  busy_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(N_SRC - 1);

    logic [CW-1:0]   count [N_SRC];
    wb_entry_t       head  [N_SRC];
    logic [N_SRC-1:0] push, pop, nonempty;

    logic            res_v_q;
    logic [4:0]      res_adr_q;
    logic [XLEN-1:0] res_data_q;
    logic [PW-1:0]   rr_q;

    logic            grant_v;
    logic [PW-1:0]   grant;
    int unsigned     idx;

    for (genvar i = 0; i < N_SRC; i++) begin : g_slot
        wb_entry_t in_entry;
        assign in_entry.adr  = src_adr[5*i +: 5];
        assign in_entry.data = src_data[XLEN*i +: XLEN];
        // Ready ignores a concurrent pop so it never depends on the grant.
        assign src_ok_o[i]   = !rst && (count[i] < DEPTH_C);
        assign push[i]       = src_v[i] && src_ok_o[i] && !flush;
        assign pop[i]        = grant_v && (grant == PW'(i)) && !flush && !rst;
        assign nonempty[i]   = (count[i] != '0);

        wb_slot_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .push       (push[i]),
            .push_entry (in_entry),
            .pop        (pop[i]),
            .count      (count[i]),
            .head       (head[i])
        );
    end

    always_comb begin
        grant_v = 1'b0;
        grant   = '0;
        idx     = 0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            idx = (int'(rr_q) + k) % N_SRC;
            if (!grant_v && nonempty[idx]) begin
                grant_v = 1'b1;
                grant   = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_v_q    <= 1'b0;
            res_adr_q  <= '0;
            res_data_q <= '0;
            rr_q       <= '0;
        end else if (flush) begin
            res_v_q <= 1'b0;
        end else if (grant_v) begin
            // x0 results still consume the grant but never write.
            res_v_q    <= (head[grant].adr != 5'd0);
            res_adr_q  <= head[grant].adr;
            res_data_q <= head[grant].data;
            rr_q       <= (grant == LAST_C) ? '0 : grant + PW'(1);
        end else begin
            res_v_q <= 1'b0;
        end
    end

    assign res_v    = res_v_q;
    assign res_adr  = res_adr_q;
    assign res_data = res_data_q;
    assign busy_o   = (|nonempty) || res_v_q;

endmodule
